matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Row-scan sequencer for the 8x8 RGB LED matrix. Takes a full frame (8 rows × 24-bit R/G/B words, the format the pattern generators produce) through a valid/ack handshake, holds it in a shadow register, and drives the matrix one row at a time. Each row is held for a programmable dwell time, followed by optional blanking. A once-per-frame `frame_done` pulse can serve as the `clk_en` for upstream pattern sources. The block sits between the pattern generators and the matrix pins.

## Interface
- `ROWS`, 8, number of matrix rows
- `COLS`, 8, LEDs per row per colour
- `DWELL`, 1000, clock cycles each row is driven (≥1)
- `BLANK`, 16, all-off cycles after each row (≥1; used only with `MATRIX_BLANK_EN`)
- `clk` input 1: system clock; all logic on rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `enable` input 1: run scanning; sampled only at frame boundaries
- `frame_in` input [ROWS-1:0][3*COLS-1:0]: frame; per row, [23:16] red, [15:8] green, [7:0] blue
- `frame_valid` input 1: `frame_in` holds a new frame
- `frame_ack` output 1: one-cycle pulse; `frame_in` captured this cycle
- `row_sel` output ROWS: one-hot active-high row enable
- `red`, `green`, `blue` output COLS each: column drive for the selected row
- `frame_done` output 1: one-cycle pulse after the last row of a frame completes

## Operation
- **States:** IDLE, LOAD, DRIVE, BLANK (BLANK exists only with `MATRIX_BLANK_EN`).
- **IDLE:** all outputs 0. If `enable` = 1, go to LOAD.
- **LOAD (1 cycle):**
  - If `frame_valid` = 1: copy `frame_in` into the shadow register and assert `frame_ack`.
  - Otherwise: keep the previous shadow and leave `frame_ack` at 0.
  - Set row index = 0 and go to DRIVE.
  - Row and colour outputs are 0 in this state.
- **DRIVE:**
  - `row_sel` = 1 << row.
  - `red`/`green`/`blue` = shadow[row] byte slices.
  - Dwell counter runs from 0 to DWELL-1, then exits to BLANK (or to the next-row logic without blanking).
- **BLANK:** all row and colour outputs 0 for BLANK cycles, then next-row logic.
- **Next-row logic:**
  - If row < ROWS-1: increment row, go to DRIVE.
  - If row = ROWS-1: row wraps to 0 and `frame_done` is asserted. Go to LOAD if `enable` = 1, else IDLE.
- **Enable handling:** dropping `enable` mid-frame does not truncate the frame. The current frame completes, then the block idles.
- **Shadow isolation:** changes to `frame_in` outside LOAD never affect the displayed image.
- **Simultaneous events:** if `frame_valid` and `enable` fall in the same cycle as the frame end, the frame still ends with `frame_done`, then the block enters IDLE with no ack.
- **Counter sizing:** the counter is `$clog2(max(DWELL,BLANK))` bits wide and is cleared on every state entry.

## Timing
- All outputs are registered.
- **Reset values:** `row_sel` = 0, `red`/`green`/`blue` = 0, `frame_ack` = 0, `frame_done` = 0, state IDLE, shadow = 0, row = 0, counter = 0.
- **Reset mid-operation:** outputs go to 0 immediately (asynchronous). Scanning restarts from IDLE after release.
- **Start-up:** `enable` rising in IDLE → LOAD on the next cycle → row 0 is driven one cycle after LOAD.
- **Frame period:** 1 + ROWS·(DWELL+BLANK) cycles with blanking; 1 + ROWS·DWELL cycles without.
- **`frame_done`:** high during the LOAD (or IDLE) cycle that follows the final row. It is not asserted on the first LOAD after IDLE.
- **`frame_ack`:** high only in a LOAD cycle with `frame_valid` = 1. The source may drop `frame_valid` the cycle after the ack.

## Configuration
- **`MATRIX_BLANK_EN` defined:** the BLANK state is present and BLANK all-off cycles separate rows (anti-ghosting).
- **`MATRIX_BLANK_EN` undefined:** no BLANK state. Rows are driven back-to-back; DRIVE of row r+1 immediately follows the last DWELL cycle of row r, and `BLANK` is ignored.

## Structure
- **Shared package `matrix_pkg`:**
  - `ROWS`/`COLS` defaults
  - `scan_state_t` enum
  - `rgb_row_t` (3·COLS-bit packed) and `frame_t` typedefs
  - localparams for the red/green/blue slice bounds
- **Sub-module `scan_timer`:** loadable down-counter with a `terminal` flag, used for both DWELL and BLANK.

## Test plan
Bench parameters: DWELL = 4, BLANK = 2, blanking enabled.

1. **Reset:** assert `reset_n` = 0 mid-DRIVE → `row_sel`, colours, `frame_ack`, `frame_done` read 0 in the same cycle; after release the block stays in IDLE while `enable` = 0.
2. **First frame:** `enable` = 1, `frame_valid` = 1, row 0 = 24'h003C00 → `frame_ack` pulses once, then `row_sel` = 8'h01, `green` = 8'h3C, `red` = `blue` = 0 for 4 cycles, then 2 all-off cycles, then `row_sel` = 8'h02.
3. **Frame period:** free-running → consecutive `frame_done` pulses exactly 49 cycles apart (33 with `MATRIX_BLANK_EN` undefined).
4. **No new frame:** `frame_valid` = 0 at a boundary → no `frame_ack`, identical row data repeats; changing `frame_in` mid-frame does not alter the outputs.
5. **Graceful stop:** `enable` dropped during row 3 → rows 3–7 still scan, `frame_done` pulses, then all outputs stay 0 in IDLE.
6. **Wrap:** row 7 is followed by LOAD then row 0 (`row_sel` 8'h80 → 0 → 8'h01); a new frame presented at that LOAD is displayed from row 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix scan path: frame layout,
// colour slice positions and the scan sequencer state encoding.
package matrix_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  // Colour byte position within a row word, in units of COLS bits.
  localparam int RED_OFS = 2;
  localparam int GRN_OFS = 1;
  localparam int BLU_OFS = 0;

  localparam int RED_HI = 3 * DEF_COLS - 1;
  localparam int RED_LO = 2 * DEF_COLS;
  localparam int GRN_HI = 2 * DEF_COLS - 1;
  localparam int GRN_LO = DEF_COLS;
  localparam int BLU_HI = DEF_COLS - 1;
  localparam int BLU_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_BLANK = 2'd3
  } scan_state_t;

  typedef logic [3*DEF_COLS-1:0] rgb_row_t;
  typedef rgb_row_t [DEF_ROWS-1:0] frame_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; terminal is high while the count sits at zero.
// Loading N gives N+1 cycles before the terminal cycle is passed.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         terminal
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign terminal = (cnt_q == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer for the RGB LED matrix: captures a frame into a shadow
// register and drives it row by row. Define MATRIX_BLANK_EN for inter-row blanking.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [ROWS-1:0][3*COLS-1:0]    frame_in,
  input  logic                           frame_valid,
  output logic                           frame_ack,
  output logic [ROWS-1:0]                row_sel,
  output logic [COLS-1:0]                red,
  output logic [COLS-1:0]                green,
  output logic [COLS-1:0]                blue,
  output logic                           frame_done
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAXC = max2(DWELL, BLANK);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_V  = CW'(DWELL - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
`ifdef MATRIX_BLANK_EN
  localparam logic [CW-1:0] BLANK_V  = CW'(BLANK - 1);
`endif

  scan_state_t                   state_q, state_d;
  logic [RW-1:0]                 row_q, row_d;
  logic [ROWS-1:0][3*COLS-1:0]   shadow_q;

  logic                          cap;
  logic                          done_d;
  logic                          row_end;
  logic                          tmr_load;
  logic [CW-1:0]                 tmr_val;
  logic                          tmr_term;

  logic [ROWS-1:0]               row_sel_d;
  logic [COLS-1:0]               red_d, green_d, blue_d;

  scan_timer #(
    .W(CW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .terminal (tmr_term)
  );

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cap      = 1'b0;
    done_d   = 1'b0;
    row_end  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = DWELL_V;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_LOAD;
          cap      = frame_valid;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end
      end
      ST_LOAD: begin
        state_d  = ST_DRIVE;
        row_d    = '0;
        tmr_load = 1'b1;
        tmr_val  = DWELL_V;
      end
      ST_DRIVE: begin
        if (tmr_term) begin
`ifdef MATRIX_BLANK_EN
          state_d  = ST_BLANK;
          tmr_load = 1'b1;
          tmr_val  = BLANK_V;
`else
          row_end  = 1'b1;
`endif
        end
      end
`ifdef MATRIX_BLANK_EN
      ST_BLANK: begin
        if (tmr_term) row_end = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A row's time is up: step to the next row or close out the frame.
    if (row_end) begin
      tmr_load = 1'b1;
      if (row_q != LAST_ROW) begin
        state_d = ST_DRIVE;
        row_d   = row_q + 1'b1;
        tmr_val = DWELL_V;
      end else begin
        row_d   = '0;
        done_d  = 1'b1;
        tmr_val = '0;
        if (enable) begin
          state_d = ST_LOAD;
          cap     = frame_valid;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    row_sel_d = '0;
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    if (state_d == ST_DRIVE) begin
      row_sel_d[row_d] = 1'b1;
      red_d            = shadow_q[row_d][RED_OFS*COLS +: COLS];
      green_d          = shadow_q[row_d][GRN_OFS*COLS +: COLS];
      blue_d           = shadow_q[row_d][BLU_OFS*COLS +: COLS];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      shadow_q   <= '0;
      frame_ack  <= 1'b0;
      frame_done <= 1'b0;
      row_sel    <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      frame_ack  <= cap;
      frame_done <= done_d;
      row_sel    <= row_sel_d;
      red        <= red_d;
      green      <= green_d;
      blue       <= blue_d;
      if (cap) shadow_q <= frame_in;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized bench for matrix_scan_ctrl against a frame-position reference model
// (DWELL=4, BLANK=2; blanking follows MATRIX_BLANK_EN).
module tb_matrix_scan_ctrl;
  import matrix_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
`ifdef MATRIX_BLANK_EN
  localparam int BLK = BLANK;
`else
  localparam int BLK = 0;
`endif
  localparam int P         = DWELL + BLK;
  localparam int FRAME_CYC = ROWS * P;
  localparam int PERIOD    = 1 + FRAME_CYC;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            frame_valid = 1'b0;
  frame_t          frame_in = '0;
  logic            frame_ack, frame_done;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] red, green, blue;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .frame_in(frame_in), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .row_sel(row_sel), .red(red), .green(green), .blue(blue),
    .frame_done(frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: mode 0 idle, 1 load, 2 scanning at offset m_pos into the frame.
  int     m_mode;
  int     m_pos;
  frame_t m_shadow;
  logic   m_ack, m_done;

  int cyc = 0;
  int last_done = -1;
  int done_seen = 0;
  bit meas_on = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_shadow = '0; m_ack = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic fv, input frame_t fi);
    bit go_load;
    go_load = 1'b0;
    m_ack   = 1'b0;
    m_done  = 1'b0;
    if (m_mode == 0) begin
      go_load = en;
    end else if (m_mode == 1) begin
      m_mode = 2;
      m_pos  = 0;
    end else if (m_pos == FRAME_CYC - 1) begin
      m_done = 1'b1;
      if (en) go_load = 1'b1;
      else m_mode = 0;
    end else begin
      m_pos++;
    end
    if (go_load) begin
      m_mode = 1;
      if (fv) begin
        m_shadow = fi;
        m_ack    = 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic [ROWS-1:0] e_rs;
    logic [COLS-1:0] e_r, e_g, e_b;
    rgb_row_t        w;
    int              r;
    e_rs = '0; e_r = '0; e_g = '0; e_b = '0;
    if (m_mode == 2 && (m_pos % P) < DWELL) begin
      r       = m_pos / P;
      e_rs[r] = 1'b1;
      w       = m_shadow[r];
      e_r     = w[RED_HI:RED_LO];
      e_g     = w[GRN_HI:GRN_LO];
      e_b     = w[BLU_HI:BLU_LO];
    end
    check("row_sel",    32'(row_sel),    32'(e_rs));
    check("red",        32'(red),        32'(e_r));
    check("green",      32'(green),      32'(e_g));
    check("blue",       32'(blue),       32'(e_b));
    check("frame_ack",  32'(frame_ack),  32'(m_ack));
    check("frame_done", 32'(frame_done), 32'(m_done));
    if (meas_on && frame_done === 1'b1) begin
      if (last_done >= 0) check("frame_period", 32'(cyc - last_done), 32'(PERIOD));
      last_done = cyc;
      done_seen++;
    end
  endtask

  task automatic tick(input logic en, input logic fv, input frame_t fi);
    enable      = en;
    frame_valid = fv;
    frame_in    = fi;
    model_step(en, fv, fi);
    @(negedge clk);
    cyc++;
    compare();
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < ROWS; i++) f[i] = rgb_row_t'($urandom);
    return f;
  endfunction

  initial begin
    frame_t f, f2;
    int k;

    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    compare();

    // Idle with enable low: valid alone must not start anything.
    repeat (6) tick(1'b0, 1'($urandom_range(0, 1)), rand_frame());

    // First frame with a known row 0.
    f    = rand_frame();
    f[0] = 24'h003C00;
    tick(1'b1, 1'b1, f);
    k = 0;
    while (frame_ack !== 1'b1 && k < 10) begin
      tick(1'b1, 1'b1, f);
      k++;
    end
    check("first_ack_seen", 32'(frame_ack), 32'd1);
    repeat (FRAME_CYC) tick(1'b1, 1'b0, f);

    // Free-running frame period.
    last_done = -1;
    done_seen = 0;
    meas_on   = 1'b1;
    repeat (3 * PERIOD + 2) tick(1'b1, 1'b0, f);
    meas_on   = 1'b0;
    check("period_pulses", 32'(done_seen >= 3), 32'd1);

    // No new frame, frame_in churning: shadow keeps the old image.
    repeat (2 * PERIOD) tick(1'b1, 1'b0, rand_frame());

    // Graceful stop during row 3.
    k = 0;
    while (!(m_mode == 2 && m_pos / P == 3) && k < 3 * PERIOD) begin
      tick(1'b1, 1'b0, f);
      k++;
    end
    check("row3_reached", 32'(k < 3 * PERIOD), 32'd1);
    k = 0;
    while (m_mode != 0 && k < 3 * PERIOD) begin
      tick(1'b0, 1'b0, rand_frame());
      k++;
    end
    check("stop_bound", 32'(k < 3 * PERIOD), 32'd1);
    repeat (10) tick(1'b0, 1'($urandom_range(0, 1)), rand_frame());

    // Restart, then present a new frame exactly at the wrap.
    tick(1'b1, 1'b0, f);
    k = 0;
    while (!(m_mode == 2 && m_pos == FRAME_CYC - 1) && k < 3 * PERIOD) begin
      tick(1'b1, 1'b0, f);
      k++;
    end
    check("wrap_reached", 32'(k < 3 * PERIOD), 32'd1);
    f2 = rand_frame();
    tick(1'b1, 1'b1, f2);
    repeat (PERIOD + 3) tick(1'b1, 1'b0, f2);

    // Random traffic.
    repeat (600) tick(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), rand_frame());

    // Asynchronous reset while a row is being driven.
    k = 0;
    while (!(m_mode == 2 && (m_pos % P) < DWELL - 1) && k < 3 * PERIOD) begin
      tick(1'b1, 1'($urandom_range(0, 1)), rand_frame());
      k++;
    end
    check("drive_reached", 32'(k < 3 * PERIOD), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_row_sel", 32'(row_sel),    32'd0);
    check("rst_red",     32'(red),        32'd0);
    check("rst_green",   32'(green),      32'd0);
    check("rst_blue",    32'(blue),       32'd0);
    check("rst_ack",     32'(frame_ack),  32'd0);
    check("rst_done",    32'(frame_done), 32'd0);
    model_reset();
    @(negedge clk);
    cyc++;
    compare();
    reset_n = 1'b1;
    repeat (8) tick(1'b0, 1'($urandom_range(0, 1)), rand_frame());
    repeat (2 * PERIOD) tick(1'b1, 1'($urandom_range(0, 1)), rand_frame());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
